// File: rtl/prog_counter.sv
// Purpose: programmable up/down counter with wrap, saturate and one-shot modes,
//          a one-cycle terminal pulse (tc), a sticky done flag and a saturating
//          terminal-event counter.
// Latency: all outputs are registered; an input change is visible one clk edge later.
// Backpressure: none; en gates stepping, and while done=1 (one-shot) en is ignored.
//
// Ports:
//   clk       sole clock, rising edge
//   reset_n   synchronous active-low reset
//   en        count enable, one step per enabled cycle
//   dir       1 = up, 0 = down
//   mode      00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
//   term_cnt  terminal value; the counting range is 0..term_cnt
//   load      load load_val into count
//   load_val  value written on load, unmodified
//   clear     synchronous clear of count, tc, done and events
//   count     current count
//   tc        one-cycle pulse in the cycle after a terminal event
//   done      sticky one-shot completion flag
//   events    saturating number of terminal events
module prog_counter #(
    parameter int WIDTH     = 8,
    parameter int EVT_W     = 8,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] term_cnt,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic [EVT_W-1:0] events
);

    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [EVT_W-1:0] EVT_ONE = EVT_W'(1);
    localparam logic [EVT_W-1:0] EVT_MAX = {EVT_W{1'b1}};

    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    logic             term_hit;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             done_nxt;
    logic [EVT_W-1:0] events_nxt;

    // Counting up, anything at or above term_cnt is terminal, so a value loaded
    // beyond the range is pulled back on the next enabled step instead of
    // running round the full 2^WIDTH space.
    assign term_hit = dir ? (count >= term_cnt) : (count == '0);

    always_comb begin
        count_nxt  = count;
        tc_nxt     = 1'b0;
        done_nxt   = done;
        events_nxt = events;
        if (clear) begin
            count_nxt  = RST_CNT;
            done_nxt   = 1'b0;
            events_nxt = '0;
        end else if (load) begin
            // events deliberately untouched by load
            count_nxt = load_val;
            done_nxt  = 1'b0;
        end else if (en && !done) begin
            if (term_hit) begin
                tc_nxt = 1'b1;
                if (events != EVT_MAX) begin
                    events_nxt = events + EVT_ONE;
                end
                case (mode)
                    MODE_SAT:     count_nxt = count;
                    MODE_ONESHOT: done_nxt  = 1'b1;
                    default:      count_nxt = dir ? '0 : term_cnt;
                endcase
            end else begin
                count_nxt = dir ? (count + CNT_ONE) : (count - CNT_ONE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count  <= RST_CNT;
            tc     <= 1'b0;
            done   <= 1'b0;
            events <= '0;
        end else begin
            count  <= count_nxt;
            tc     <= tc_nxt;
            done   <= done_nxt;
            events <= events_nxt;
        end
    end

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter WIDTH, default 8, count register width (>=2).
REQ-002 Parameter EVT_W, default 8, terminal-event counter width (>=1).
REQ-003 Parameter RESET_VAL, default 0, value of count after reset/clear.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 en  input  1  count enable; one step per enabled cycle.
REQ-007 dir  input  1  1 = count up, 0 = count down.
REQ-008 mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap).
REQ-009 term_cnt  input  WIDTH  runtime terminal value (upper bound of range 0..term_cnt).
REQ-010 load  input  1  load load_val into count.
REQ-011 load_val  input  WIDTH  value loaded when load=1.
REQ-012 clear  input  1  synchronous clear of count, done, events.
REQ-013 count  output  WIDTH  registered current count.
REQ-014 tc  output  1  registered one-cycle terminal-event pulse.
REQ-015 done  output  1  registered sticky one-shot completion flag.
REQ-016 events  output  EVT_W  registered saturating count of terminal events.

Function
REQ-017 Per-edge priority SHALL be: reset_n=0 > clear > load > en; only the highest active action takes effect.
REQ-018 Terminal condition SHALL be: up, count >= term_cnt; down, count == 0.
REQ-019 Terminal event SHALL occur when en=1, done=0, no clear/load, and the terminal condition holds.
REQ-020 en=1 without terminal condition SHALL step count by +1 (up) or -1 (down), modulo 2^WIDTH.
REQ-021 Wrap mode on terminal event: up -> count=0; down -> count=term_cnt.
REQ-022 Saturate mode on terminal event: count holds (count above term_cnt counting up holds its value).
REQ-023 One-shot mode on terminal event: count holds, done<=1; while done=1, en SHALL be ignored.
REQ-024 done SHALL clear only on reset, clear or load; it SHALL never set outside one-shot mode.
REQ-025 tc SHALL be 1 exactly in the cycle after each terminal event, otherwise 0; saturate mode at terminal with en held SHALL pulse tc every enabled cycle.
REQ-026 events SHALL increment by 1 per terminal event and saturate at 2^EVT_W-1; it SHALL not be affected by load.
REQ-027 load SHALL write load_val unmodified even if load_val > term_cnt; tc SHALL be 0 in the following cycle.
REQ-028 Changes to dir, mode or term_cnt SHALL take effect at the next edge with no pipeline delay; count is not adjusted when term_cnt changes.
REQ-029 term_cnt=0 SHALL make every enabled up-count a terminal event (count stays/returns 0).
REQ-030 en=0 with no clear/load SHALL hold all state; tc SHALL be 0.

Reset
REQ-031 reset_n=0 at an edge SHALL set count=RESET_VAL, tc=0, done=0, events=0, regardless of other inputs.
REQ-032 Reset SHALL be sampled only on clk rising edges; mid-operation reset SHALL abort with no terminal event recorded.
REQ-033 clear SHALL have the same effect as reset on count, tc, done and events.

Verification (WIDTH=4, EVT_W=2, RESET_VAL=0)
REQ-034 Wrap up: term_cnt=5, dir=1, en=1 for 14 cycles -> count 1,2,3,4,5,0,1,...; tc high the cycle count shows 0; events=2.
REQ-035 Wrap down: load_val=2 loaded, term_cnt=9, dir=0, en=1 -> count 1,0,9,8; tc high the cycle count shows 9.
REQ-036 One-shot: mode=10, term_cnt=3, count from 0 -> count 1,2,3, done=1, count stays 3 with en=1; load 0 -> done=0, counting resumes.
REQ-037 Saturate/events: mode=01, term_cnt=2, en=1 for 8 cycles -> count sticks at 2, tc high each cycle after reaching 2, events saturates at 3.
REQ-038 Priority: reset_n=0 with clear=1, load=1, load_val=7, en=1 -> count=0, all flags 0; then clear+load together -> count=0; load+en -> count=load_val.
REQ-039 Out-of-range load: term_cnt=4, load_val=12, dir=1, mode=00, en=1 -> next count 0, tc=1.
